// File: rtl/clk_freq_meter.sv
// Gated edge counter measuring sig_in rising edges per GATE_CYCLES window,
// with valid/ready result hand-off, range check and lock detection.
module clk_freq_meter #(
  parameter int GATE_CYCLES = 27000,
  parameter int CNT_W       = 16,
  parameter int EXP_MIN     = 0,
  parameter int EXP_MAX     = 65535,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overflow,
  output logic             overrun,
  output logic             in_range,
  output logic             locked
);
  localparam int TW = $clog2(GATE_CYCLES);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_MAX = '1;
  localparam logic [MW-1:0] M_LOCK = MW'(LOCK_COUNT);
  localparam logic signed [63:0] LO = 64'(EXP_MIN);
  localparam logic signed [63:0] HI = 64'(EXP_MAX);

  typedef enum logic {IDLE, GATE} state_t;

  state_t           state, state_nx;
  logic             s1, s2, s3;
  logic             rise;
  logic [TW-1:0]    tmr, tmr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ovf, ovf_nx;
  logic [MW-1:0]    match, match_nx;
  logic             term, abort;
  logic [CNT_W-1:0] fin_cnt;
  logic             fin_ovf;
  logic             fin_inr;
  logic signed [63:0] fin_s;

  assign rise  = s2 & ~s3;
  assign term  = (state == GATE) && enable && (tmr == T_LAST);
  assign abort = (state == GATE) && !enable;

  // running count including this cycle's edge, saturating
  always_comb begin
    fin_cnt = cnt;
    fin_ovf = ovf;
    if (rise) begin
      if (cnt == C_MAX) fin_ovf = 1'b1;
      else fin_cnt = cnt + CNT_W'(1);
    end
  end

  assign fin_s   = 64'(fin_cnt);
  assign fin_inr = (fin_s >= LO) && (fin_s <= HI) && !fin_ovf;
  assign locked  = (match == M_LOCK);

  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    cnt_nx   = cnt;
    ovf_nx   = ovf;
    match_nx = match;
    unique case (state)
      IDLE: begin
        tmr_nx = '0;
        cnt_nx = '0;
        ovf_nx = 1'b0;
        if (enable) state_nx = GATE;
      end
      GATE: begin
        if (!enable) begin
          state_nx = IDLE;
          tmr_nx   = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
          match_nx = '0;
        end else if (term) begin
          tmr_nx = '0;
          cnt_nx = '0;
          ovf_nx = 1'b0;
          if (!fin_inr) match_nx = '0;
          else if (match != M_LOCK) match_nx = match + MW'(1);
        end else begin
          tmr_nx = tmr + TW'(1);
          cnt_nx = fin_cnt;
          ovf_nx = fin_ovf;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      tmr        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      match      <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
      overflow   <= 1'b0;
      overrun    <= 1'b0;
      in_range   <= 1'b0;
    end else begin
      s1    <= sig_in;
      s2    <= s1;
      s3    <= s2;
      state <= state_nx;
      tmr   <= tmr_nx;
      cnt   <= cnt_nx;
      ovf   <= ovf_nx;
      match <= match_nx;
      if (term) begin
        in_range <= fin_inr;
        if (!meas_valid || meas_ready) begin
          meas_count <= fin_cnt;
          overflow   <= fin_ovf;
          meas_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else begin
        if (meas_valid && meas_ready) meas_valid <= 1'b0;
        if (abort) in_range <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_clk_freq_meter.sv
// Randomized-phase bench for clk_freq_meter; window counts come from a
// list of sig_in rise times, each counted 3 clocks after it is driven.
module tb_clk_freq_meter;
  localparam int GC = 100;

  logic clk = 0, rst = 1, sig_in = 0;
  logic en_a = 0, en_b = 0, rdy_a = 1, rdy_b = 1;
  logic [7:0] cnt_a;
  logic vld_a, ovf_a, ovr_a, inr_a, lck_a;
  logic [3:0] cnt_b;
  logic vld_b, ovf_b, ovr_b, inr_b, lck_b;

  int total = 0, bad = 0;
  int cyc = 0, per = 0, last_per = 0, ph = 0;
  int rises[$];
  int wend, match_m, cnt_m;
  bit vld_m, ovr_m, ovf_m;

  clk_freq_meter #(.GATE_CYCLES(GC), .CNT_W(8), .EXP_MIN(9),
    .EXP_MAX(11), .LOCK_COUNT(3)) dut_a (
    .clk(clk), .rst(rst), .sig_in(sig_in), .enable(en_a),
    .meas_count(cnt_a), .meas_valid(vld_a), .meas_ready(rdy_a),
    .overflow(ovf_a), .overrun(ovr_a), .in_range(inr_a),
    .locked(lck_a));

  clk_freq_meter #(.GATE_CYCLES(GC), .CNT_W(4), .EXP_MIN(9),
    .EXP_MAX(11), .LOCK_COUNT(3)) dut_b (
    .clk(clk), .rst(rst), .sig_in(sig_in), .enable(en_b),
    .meas_count(cnt_b), .meas_valid(vld_b), .meas_ready(rdy_b),
    .overflow(ovf_b), .overrun(ovr_b), .in_range(inr_b),
    .locked(lck_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // square wave of period per; each rise is logged at its count edge
  always @(posedge clk) begin
    #1;
    if (per != last_per) begin
      ph = 0;
      last_per = per;
    end
    if (per == 0) sig_in = 0;
    else begin
      if (ph >= per) ph = 0;
      if (ph < per / 2 && !sig_in) rises.push_back(cyc + 3);
      sig_in = (ph < per / 2);
      ph++;
    end
  end

  function automatic int n_rises(int lo, int hi);
    int n = 0;
    foreach (rises[i]) if (rises[i] > lo && rises[i] <= hi) n++;
    return n;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(int e);
    while (cyc < e) step();
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) step();
    total += 6;
    if (cnt_a !== 8'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", cnt_a); end
    if (vld_a !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", vld_a); end
    if (ovf_a !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b want=0", ovf_a); end
    if (ovr_a !== 1'b0) begin bad++; $display("FAIL rst_ovr got=%b want=0", ovr_a); end
    if (inr_a !== 1'b0 || lck_a !== 1'b0) begin
      bad++; $display("FAIL rst_rng got=%b%b want=00", inr_a, lck_a);
    end
    if (vld_b !== 1'b0) begin bad++; $display("FAIL rst_valid_b got=%b want=0", vld_b); end
    rst = 0;
    step();
  endtask

  task automatic test_overflow;
    int g, raw, ec;
    bit eo, ei;
    per = 4;
    repeat (20 + $urandom_range(0, 7)) step();
    g = cyc + 1;
    en_b = 1;
    for (int w = 1; w <= 2; w++) begin
      wait_to(g + GC * w);
      raw = n_rises(g + GC * (w - 1), g + GC * w);
      eo = raw > 15;
      ec = eo ? 15 : raw;
      ei = !eo && raw >= 9 && raw <= 11;
      total += 5;
      if (cnt_b !== 4'(ec)) begin bad++; $display("FAIL ovf_count w%0d got=%0d want=%0d", w, cnt_b, ec); end
      if (ovf_b !== eo) begin bad++; $display("FAIL ovf_flag w%0d got=%b want=%b", w, ovf_b, eo); end
      if (inr_b !== ei) begin bad++; $display("FAIL ovf_inr w%0d got=%b want=%b", w, inr_b, ei); end
      if (vld_b !== 1'b1) begin bad++; $display("FAIL ovf_valid w%0d got=%b want=1", w, vld_b); end
      if (lck_b !== 1'b0) begin bad++; $display("FAIL ovf_lock w%0d got=%b want=0", w, lck_b); end
    end
    en_b = 0;
  endtask

  task automatic next_window(int p_after, bit rdy, string tag);
    int raw, ec;
    bit eo, ei, ld;
    rdy_a = rdy;
    wait_to(wend + GC - 3);
    per = p_after;
    wait_to(wend + GC);
    raw = n_rises(wend, wend + GC);
    wend += GC;
    eo = raw > 255;
    ec = eo ? 255 : raw;
    ei = !eo && raw >= 9 && raw <= 11;
    ld = !vld_m || rdy;
    if (ld) begin
      cnt_m = ec;
      ovf_m = eo;
    end else ovr_m = 1;
    vld_m = 1;
    match_m = ei ? (match_m < 3 ? match_m + 1 : 3) : 0;
    total += 6;
    if (cnt_a !== 8'(cnt_m)) begin bad++; $display("FAIL %s count got=%0d want=%0d", tag, cnt_a, cnt_m); end
    if (ovf_a !== ovf_m) begin bad++; $display("FAIL %s ovf got=%b want=%b", tag, ovf_a, ovf_m); end
    if (vld_a !== 1'b1) begin bad++; $display("FAIL %s valid got=%b want=1", tag, vld_a); end
    if (ovr_a !== ovr_m) begin bad++; $display("FAIL %s overrun got=%b want=%b", tag, ovr_a, ovr_m); end
    if (inr_a !== ei) begin bad++; $display("FAIL %s in_range got=%b want=%b", tag, inr_a, ei); end
    if (lck_a !== (match_m == 3)) begin
      bad++; $display("FAIL %s locked got=%b want=%b", tag, lck_a, match_m == 3);
    end
  endtask

  task automatic test_lock;
    per = 10;
    repeat (20 + $urandom_range(0, 9)) step();
    wend = cyc + 1;
    en_a = 1;
    match_m = 0; vld_m = 0; ovr_m = 0; cnt_m = 0; ovf_m = 0;
    next_window(10, 1, "lock1");
    next_window(10, 1, "lock2");
    next_window(4, 1, "lock3");
    next_window(10, 1, "fast");
    next_window(10, 1, "relock1");
    next_window(10, 1, "relock2");
    next_window(10, 1, "relock3");
  endtask

  task automatic test_back_to_back;
    next_window(4, 0, "hold1");
    next_window(10, 0, "hold2");
    rdy_a = 1;
    step();
    vld_m = 0;
    total++;
    if (vld_a !== 1'b0) begin bad++; $display("FAIL drop_valid got=%b want=0", vld_a); end
    next_window(10, 1, "after_hold");
  endtask

  task automatic test_abort;
    int e0;
    rdy_a = 1;
    wait_to(wend + 50);
    en_a = 0;
    step();
    vld_m = 0;
    match_m = 0;
    total += 5;
    if (lck_a !== 1'b0) begin bad++; $display("FAIL abort_lock got=%b want=0", lck_a); end
    if (inr_a !== 1'b0) begin bad++; $display("FAIL abort_inr got=%b want=0", inr_a); end
    if (ovr_a !== ovr_m) begin bad++; $display("FAIL abort_ovr got=%b want=%b", ovr_a, ovr_m); end
    if (cnt_a !== 8'(cnt_m)) begin bad++; $display("FAIL abort_count got=%0d want=%0d", cnt_a, cnt_m); end
    if (vld_a !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", vld_a); end
    repeat (60 + $urandom_range(0, 20)) step();
    total++;
    if (vld_a !== 1'b0) begin bad++; $display("FAIL abort_noresult got=%b want=0", vld_a); end
    e0 = cyc;
    wend = e0 + 1;
    en_a = 1;
    wait_to(e0 + GC);
    total++;
    if (vld_a !== 1'b0) begin bad++; $display("FAIL reen_early got=%b want=0", vld_a); end
    next_window(10, 1, "reen");
  endtask

  task automatic test_rst_terminal;
    rdy_a = 0;
    wait_to(wend + GC - 1);
    total++;
    if (vld_a !== 1'b1) begin bad++; $display("FAIL term_pre_valid got=%b want=1", vld_a); end
    rst = 1;
    step();
    rst = 0;
    total += 4;
    if (cnt_a !== 8'd0) begin bad++; $display("FAIL term_count got=%0d want=0", cnt_a); end
    if (vld_a !== 1'b0 || ovf_a !== 1'b0) begin
      bad++; $display("FAIL term_valid got=%b%b want=00", vld_a, ovf_a);
    end
    if (ovr_a !== 1'b0) begin bad++; $display("FAIL term_ovr got=%b want=0", ovr_a); end
    if (inr_a !== 1'b0 || lck_a !== 1'b0) begin
      bad++; $display("FAIL term_rng got=%b%b want=00", inr_a, lck_a);
    end
    step();
    total++;
    if (vld_a !== 1'b0) begin bad++; $display("FAIL term_after got=%b want=0", vld_a); end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_lock();
    test_back_to_back();
    test_abort();
    test_rst_terminal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
